// File: rtl/sprdma.sv
`default_nettype none
// ============================================================================
// Module   : sprdma
// Purpose  : Sprite DMA engine. A CPU write to DMA_REG_ADDR stalls the CPU
//            and copies one 256-byte page to the PPU OAM data register as
//            one wait cycle followed by 256 read/write bus cycle pairs.
// Revision : 1.0 - initial release
// ============================================================================
module sprdma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] cpu_a_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  mem_d_in,
  output logic [15:0] mem_a_out,
  output logic [7:0]  mem_d_out,
  output logic        mem_r_nw_out,
  output logic        cpu_rdy_out,
  output logic        active_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_page;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic       w_trigger;

  // A CPU write to the DMA register only starts a transfer from IDLE;
  // the same write while busy is swallowed along with all other CPU traffic.
  assign w_trigger = (r_state == S_IDLE) && !cpu_r_nw_in &&
                     (cpu_a_in == DMA_REG_ADDR);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Page/counter/data registers: latch page on trigger, capture read data,
  // advance the byte counter after each OAM write (8-bit wrap, no page carry)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_page <= 8'h00;
      r_cnt  <= 8'h00;
      r_data <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page <= cpu_d_in;
            r_cnt  <= 8'h00;
          end
        end
        S_READ:  r_data <= mem_d_in;
        S_WRITE: r_cnt  <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Next state and bus muxing; IDLE passes the CPU bus straight through
  always_comb begin
    w_state_next = r_state;
    mem_a_out    = cpu_a_in;
    mem_d_out    = cpu_d_in;
    mem_r_nw_out = cpu_r_nw_in;
    active_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        active_out   = 1'b1;
        mem_a_out    = cpu_a_in;
        mem_d_out    = r_data;
        mem_r_nw_out = 1'b1;
        w_state_next = S_READ;
      end
      S_READ: begin
        active_out   = 1'b1;
        mem_a_out    = {r_page, r_cnt};
        mem_d_out    = r_data;
        mem_r_nw_out = 1'b1;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        active_out   = 1'b1;
        mem_a_out    = OAM_DATA_ADDR;
        mem_d_out    = r_data;
        mem_r_nw_out = 1'b0;
        w_state_next = (r_cnt == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign cpu_rdy_out = ~active_out;

endmodule
`default_nettype wire

// File: tb/tb_sprdma.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprdma
// Purpose  : Randomized self-checking bench for sprdma against a queue-based
//            model of the expected bus cycle sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprdma;

  localparam logic [15:0] DMA_A = 16'h4014;
  localparam logic [15:0] OAM_A = 16'h2004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  mem_d;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_rnw;
  logic        rdy;
  logic        active;

  always #10 clk = ~clk;

  sprdma #(.DMA_REG_ADDR(DMA_A), .OAM_DATA_ADDR(OAM_A)) u_dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .cpu_a_in    (cpu_a),
    .cpu_d_in    (cpu_d),
    .cpu_r_nw_in (cpu_rnw),
    .mem_d_in    (mem_d),
    .mem_a_out   (mem_a),
    .mem_d_out   (mem_dout),
    .mem_r_nw_out(mem_rnw),
    .cpu_rdy_out (rdy),
    .active_out  (active)
  );

  // Memory contents: byte at address a is a[7:0] ^ 8'h5A
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  assign mem_d = mem_byte(mem_a);

  // One expected DMA bus cycle
  typedef struct packed {
    logic        is_wait;
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  data;
    logic        chk_d;
    logic [15:0] src;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   run_len = 0;
  bit   aborted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A DMA of page p: one wait cycle then 256 read/write pairs
  task automatic push_dma(input logic [7:0] p);
    q.push_back('{1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000});
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {p, 8'(i)};
      q.push_back('{1'b0, a, 1'b1, 8'h00, 1'b0, a});
      q.push_back('{1'b0, OAM_A, 1'b0, mem_byte(a), 1'b1, a});
    end
  endtask

  // Apply one bus cycle and check the DMA outputs against the model
  task automatic drive_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    bit was_idle;
    cpu_a = a; cpu_d = d; cpu_rnw = rnw;
    @(negedge clk);
    was_idle = (q.size() == 0);
    if (was_idle) begin
      chk("idle_active", 32'(active), 32'd0);
      chk("idle_rdy", 32'(rdy), 32'd1);
      chk("idle_addr", 32'(mem_a), 32'(a));
      chk("idle_data", 32'(mem_dout), 32'(d));
      chk("idle_rnw", 32'(mem_rnw), 32'(rnw));
    end else begin
      chk("dma_active", 32'(active), 32'd1);
      chk("dma_rdy", 32'(rdy), 32'd0);
      chk("dma_addr", 32'(mem_a), q[0].is_wait ? 32'(a) : 32'(q[0].addr));
      chk("dma_rnw", 32'(mem_rnw), 32'(q[0].rnw));
      if (q[0].chk_d) chk("dma_wdata", 32'(mem_dout), 32'(q[0].data));
    end
    if (active) begin
      run_len++;
    end else if (run_len != 0) begin
      if (!aborted) chk("dma_len", 32'(run_len), 32'd513);
      run_len = 0;
      aborted = 1'b0;
    end
    @(posedge clk);
    if (!was_idle) void'(q.pop_front());
    else if (!rnw && a == DMA_A) push_dma(d);
    #1;
  endtask

  // Random CPU cycle; optionally forces a DMA-register write
  task automatic rand_cycle(input int trig_pct);
    logic [15:0] a;
    logic        rnw;
    a   = 16'($urandom);
    rnw = 1'($urandom);
    if ($urandom_range(99) < trig_pct) begin
      a = DMA_A; rnw = 1'b0;
    end else if (a == DMA_A) begin
      rnw = 1'b1;
    end
    drive_cycle(a, 8'($urandom), rnw);
  endtask

  task automatic run_until_idle(input int trig_pct);
    int n;
    n = 0;
    while (q.size() != 0 && n < 700) begin
      rand_cycle(trig_pct);
      n++;
    end
    if (q.size() != 0) chk("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #5;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_passthru", 32'(mem_a), 32'(cpu_a));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through of ordinary CPU traffic
    drive_cycle(16'h2002, 8'h00, 1'b1);
    drive_cycle(16'h2000, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++) rand_cycle(0);

    // Page 2 DMA with stray DMA-register writes while busy
    drive_cycle(DMA_A, 8'h02, 1'b0);
    run_until_idle(5);

    // Back-to-back trigger in the first IDLE cycle, then reset during 0x0340 write
    drive_cycle(DMA_A, 8'h03, 1'b0);
    begin
      int n;
      n = 0;
      while (!(q.size() != 0 && !q[0].rnw && q[0].src == 16'h0340) && n < 700) begin
        rand_cycle(0);
        n++;
      end
      if (n >= 700) chk("abort_timeout", 32'(n), 32'd0);
    end
    cpu_a = 16'h1234; cpu_d = 8'h77; cpu_rnw = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_active", 32'(active), 32'd0);
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_addr", 32'(mem_a), 32'h1234);
    chk("abort_rnw", 32'(mem_rnw), 32'd0);
    @(posedge clk); #1;
    q.delete();
    aborted = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) rand_cycle(0);

    // Top page, frequent DMA-register writes during the transfer
    drive_cycle(DMA_A, 8'hFF, 1'b0);
    run_until_idle(30);
    for (int i = 0; i < 10; i++) rand_cycle(0);

    // A few random-page DMAs launched from random idle traffic
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (q.size() == 0 && n < 200) begin
        rand_cycle(10);
        n++;
      end
      run_until_idle(10);
    end
    for (int i = 0; i < 5; i++) rand_cycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning the CPU address whose write starts a sprite DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, meaning the PPU OAM data register address targeted by DMA writes.
REQ-003 SHALL have port clk_in, input, 1, the single system clock (50MHz); all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, reset; it is asynchronous and active-low.
REQ-005 SHALL have port cpu_a_in, input, 16, CPU address bus; every clock is one bus cycle.
REQ-006 SHALL have port cpu_d_in, input, 8, CPU write data.
REQ-007 SHALL have port cpu_r_nw_in, input, 1, CPU read (1) / write (0) select.
REQ-008 SHALL have port mem_d_in, input, 8, memory read data, valid at the clock edge that ends a read cycle.
REQ-009 SHALL have port mem_a_out, output, 16, shared memory bus address.
REQ-010 SHALL have port mem_d_out, output, 8, shared memory bus write data.
REQ-011 SHALL have port mem_r_nw_out, output, 1, shared memory bus read/write select.
REQ-012 SHALL have port cpu_rdy_out, output, 1, CPU ready; 0 stalls the CPU.
REQ-013 SHALL have port active_out, output, 1, high while DMA owns the bus.

Function
REQ-014 SHALL implement states IDLE, WAIT, READ, WRITE.
REQ-015 SHALL register 8-bit page and 8-bit byte counter; byte address = {page, counter}.
REQ-016 In IDLE, mem_a_out/mem_d_out/mem_r_nw_out SHALL pass cpu_a_in/cpu_d_in/cpu_r_nw_in through combinationally.
REQ-017 Trigger: IDLE, cpu_r_nw_in=0, cpu_a_in=DMA_REG_ADDR at a clock edge -> page<=cpu_d_in, counter<=0, state<=WAIT.
REQ-018 That trigger write SHALL also pass through to the bus unchanged in its own cycle.
REQ-019 WAIT SHALL last exactly one cycle, driving mem_r_nw_out=1, mem_a_out=cpu_a_in, then go to READ.
REQ-020 READ SHALL drive mem_a_out={page,counter}, mem_r_nw_out=1; at cycle end capture mem_d_in into an 8-bit data register; go to WRITE.
REQ-021 WRITE SHALL drive mem_a_out=OAM_DATA_ADDR, mem_d_out=data register, mem_r_nw_out=0; at cycle end counter<=counter+1 (8-bit wrap).
REQ-022 WRITE with counter=8'hFF SHALL go to IDLE (counter wraps to 0); otherwise go to READ.
REQ-023 active_out SHALL be 1 exactly in WAIT/READ/WRITE; cpu_rdy_out SHALL equal ~active_out.
REQ-024 A DMA SHALL occupy exactly 513 active cycles: 1 WAIT + 256 READ/WRITE pairs.
REQ-025 CPU bus activity (including writes to DMA_REG_ADDR) while active SHALL be ignored and SHALL not reach the bus.
REQ-026 In non-IDLE states mem_d_out SHALL equal the data register (READ/WAIT values are don't-care for the bus but must be deterministic).
REQ-027 A trigger at the same edge that returns to IDLE SHALL not exist by construction; a trigger in the first IDLE cycle after completion SHALL start a new DMA normally.
REQ-028 Page 8'hFF SHALL read 16'hFF00..16'hFFFF with no carry out of the counter into page.

Reset
REQ-029 rst_n_in low SHALL immediately force state=IDLE, page=0, counter=0, data register=0, active_out=0, cpu_rdy_out=1.
REQ-030 Reset asserted mid-DMA SHALL abort with no further WRITE cycles; after release the block SHALL be IDLE in pass-through.

Verification
REQ-031 Write 8'h02 to 16'h4014 -> next cycle active_out=1, cpu_rdy_out=0; then reads 16'h0200..16'h02FF alternating with writes to 16'h2004 carrying each byte read; active exactly 513 cycles.
REQ-032 Memory model with byte[i]=i^8'h5A -> 256 WRITE cycles emit data 8'h5A,8'h5B,... in order, each matching its preceding READ address.
REQ-033 IDLE, CPU reads 16'h2002 and writes 8'h80 to 16'h2000 -> mem bus mirrors CPU bus same cycle; active_out stays 0.
REQ-034 Assert rst_n_in during WRITE of byte 16'h0340 -> active_out=0 and cpu_rdy_out=1 asynchronously; no bus writes after release until a new trigger.
REQ-035 Page 8'hFF DMA followed by a CPU write to 16'h4014 during it -> addresses stay 16'hFF00..16'hFFFF, in-flight write ignored, exactly one 513-cycle DMA.
REQ-036 Second trigger (page 8'h03) in first IDLE cycle after a DMA ends -> new DMA starts, reads begin at 16'h0300.
